// File: rtl/ahb_bus_arbiter_if.sv
// rtl/ahb_bus_arbiter_if.sv - request, response and grant signals shared by the masters, the slave and the arbiter
interface ahb_bus_arbiter_if;
  logic       busreq_1;
  logic       busreq_2;
  logic       ready;
  logic [1:0] response;
  logic       split_clr_1;
  logic       split_clr_2;
  logic       grant_1;
  logic       grant_2;
  logic [1:0] master_id;
  logic [1:0] split_mask;
  logic       err_pulse;

  // Arbiter side: samples requests and slave status, drives grants.
  modport slave (
    input  busreq_1, busreq_2, ready, response, split_clr_1, split_clr_2,
    output grant_1, grant_2, master_id, split_mask, err_pulse
  );

  // Environment side: masters and slave drive requests and status.
  modport master (
    output busreq_1, busreq_2, ready, response, split_clr_1, split_clr_2,
    input  grant_1, grant_2, master_id, split_mask, err_pulse
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - two-master arbiter with split masking and beat limit; optional macro ARB_ROUND_ROBIN_EN
module ahb_bus_arbiter #(
  parameter int BEAT_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  ahb_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN1 = 2'b01,
    OWN2 = 2'b10
  } state_t;

  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;
  localparam logic [3:0] BEAT_LAST  = 4'(BEAT_MAX - 1);

  state_t     state_q, state_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] master_id_q, master_id_d;
  logic [1:0] split_mask_q, split_mask_d;
  logic       err_q, err_d;

  logic       elig_1, elig_2;
  logic       owner_req, other_elig;
  state_t     other_state;
  state_t     owner_state;
  state_t     tie_winner;
  state_t     arb_pick;
  logic [1:0] split_set;

  // A master is a candidate only while requesting and not parked by a SPLIT.
  assign elig_1 = bus.busreq_1 & ~split_mask_q[0];
  assign elig_2 = bus.busreq_2 & ~split_mask_q[1];

`ifdef ARB_ROUND_ROBIN_EN
  // Last tenure owner: 0 = master 1, 1 = master 2; starts at master 2 so master 1 wins first.
  logic last_owner_q, last_owner_d;

  // Remember who held the bus most recently; IDLE keeps the previous owner.
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == OWN1) last_owner_d = 1'b0;
    else if (state_q == OWN2) last_owner_d = 1'b1;
  end

  // Last-owner register; reset value gives master 1 the first contest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_owner_q <= 1'b1;
    else     last_owner_q <= last_owner_d;
  end

  assign tie_winner = last_owner_q ? OWN1 : OWN2;
`else
  assign tie_winner = OWN1;
`endif

  // Fresh arbitration among eligible masters, used from IDLE.
  always_comb begin
    arb_pick = IDLE;
    if (elig_1 && elig_2) arb_pick = tie_winner;
    else if (elig_1)      arb_pick = OWN1;
    else if (elig_2)      arb_pick = OWN2;
  end

  // Owner-relative view so the boundary rules are written once for both masters.
  always_comb begin
    owner_state = state_q;
    owner_req   = 1'b0;
    other_elig  = 1'b0;
    other_state = IDLE;
    split_set   = 2'b00;
    if (state_q == OWN1) begin
      owner_req   = bus.busreq_1;
      other_elig  = elig_2;
      other_state = OWN2;
      split_set   = 2'b01;
    end else if (state_q == OWN2) begin
      owner_req   = bus.busreq_2;
      other_elig  = elig_1;
      other_state = OWN1;
      split_set   = 2'b10;
    end
  end

  // Next-state, beat counter and mask: grants only move on ready beats while owned.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    split_mask_d = split_mask_q & ~{bus.split_clr_2, bus.split_clr_1};
    unique case (state_q)
      IDLE: begin
        state_d    = arb_pick;
        beat_cnt_d = 4'd0;
      end
      OWN1, OWN2: begin
        if (bus.ready) begin
          if (bus.response == RESP_SPLIT) begin
            // Owner is parked; the set is OR-ed last so it beats a same-cycle clear.
            split_mask_d = split_mask_d | split_set;
            beat_cnt_d   = 4'd0;
            state_d      = other_elig ? other_state : IDLE;
          end else if (bus.response == RESP_RETRY) begin
            beat_cnt_d = 4'd0;
            state_d    = other_elig ? other_state : owner_state;
          end else if (!owner_req) begin
            beat_cnt_d = 4'd0;
            state_d    = other_elig ? other_state : IDLE;
          end else if (beat_cnt_q == BEAT_LAST && other_elig) begin
            beat_cnt_d = 4'd0;
            state_d    = other_state;
          end else if (beat_cnt_q != BEAT_LAST) begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = 4'd0;
      end
    endcase
  end

  // Data-phase owner follows the address-phase owner one accepted beat later.
  always_comb begin
    master_id_d = master_id_q;
    if (bus.ready) master_id_d = state_q;
  end

  // ERROR is reported for one cycle but otherwise handled like OKAY.
  always_comb begin
    err_d = bus.ready && (bus.response == RESP_ERROR);
  end

  // State and status registers; reset drops every tenure and split mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= 4'd0;
      master_id_q  <= 2'b00;
      split_mask_q <= 2'b00;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      master_id_q  <= master_id_d;
      split_mask_q <= split_mask_d;
      err_q        <= err_d;
    end
  end

  assign bus.grant_1    = (state_q == OWN1);
  assign bus.grant_2    = (state_q == OWN2);
  assign bus.master_id  = master_id_q;
  assign bus.split_mask = split_mask_q;
  assign bus.err_pulse  = err_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - scoreboard bench for the two-master arbiter
module tb_ahb_bus_arbiter;
  localparam int BEAT_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ahb_bus_arbiter_if bus();

  ahb_bus_arbiter #(.BEAT_MAX(BEAT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       g1;
    logic       g2;
    logic [1:0] mid;
    logic [1:0] msk;
    logic       err;
  } exp_t;

  exp_t sb[$];

  // Reference state: st 0 idle, 1 master 1, 2 master 2.
  int m_st, m_bc, m_mid, m_msk, m_err, m_last;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_bc = 0; m_mid = 0; m_msk = 0; m_err = 0; m_last = 2;
  endtask

  function automatic int tie_pick();
`ifdef ARB_ROUND_ROBIN_EN
    return (m_last == 1) ? 2 : 1;
`else
    return 1;
`endif
  endfunction

  task automatic model_step(input bit b1, input bit b2, input bit rdy, input bit [1:0] resp,
                            input bit c1, input bit c2);
    bit e[3];
    bit rq[3];
    int n_st, n_bc, set, o, oth;
    e[0] = 0; rq[0] = 0;
    e[1] = b1 && !m_msk[0];
    e[2] = b2 && !m_msk[1];
    rq[1] = b1; rq[2] = b2;
    n_st = m_st; n_bc = m_bc; set = 0;
    if (m_st == 0) begin
      n_bc = 0;
      if (e[1] && e[2]) n_st = tie_pick();
      else if (e[1])    n_st = 1;
      else if (e[2])    n_st = 2;
      else              n_st = 0;
    end else if (rdy) begin
      o = m_st; oth = 3 - m_st;
      if (resp == 2'b11) begin
        set = (o == 1) ? 1 : 2; n_bc = 0; n_st = e[oth] ? oth : 0;
      end else if (resp == 2'b10) begin
        n_bc = 0; n_st = e[oth] ? oth : o;
      end else if (!rq[o]) begin
        n_bc = 0; n_st = e[oth] ? oth : 0;
      end else if (m_bc == BEAT_MAX - 1 && e[oth]) begin
        n_bc = 0; n_st = oth;
      end else if (m_bc < BEAT_MAX - 1) begin
        n_bc = m_bc + 1;
      end
    end
    if (rdy) m_mid = m_st;
    m_msk = (m_msk & ~((c2 ? 2 : 0) | (c1 ? 1 : 0))) | set;
    m_err = (rdy && resp == 2'b01) ? 1 : 0;
    if (m_st != 0) m_last = m_st;
    m_st = n_st;
    m_bc = n_bc;
  endtask

  task automatic cyc(input bit b1, input bit b2, input bit rdy, input bit [1:0] resp,
                     input bit c1 = 1'b0, input bit c2 = 1'b0);
    exp_t x;
    exp_t e;
    @(negedge clk);
    bus.busreq_1 = b1; bus.busreq_2 = b2; bus.ready = rdy;
    bus.response = resp; bus.split_clr_1 = c1; bus.split_clr_2 = c2;
    model_step(b1, b2, rdy, resp, c1, c2);
    x.g1  = (m_st == 1);
    x.g2  = (m_st == 2);
    x.mid = 2'(m_mid);
    x.msk = 2'(m_msk);
    x.err = (m_err != 0);
    sb.push_back(x);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("grant_1", 8'(bus.grant_1), 8'(e.g1));
    chk("grant_2", 8'(bus.grant_2), 8'(e.g2));
    chk("master_id", 8'(bus.master_id), 8'(e.mid));
    chk("split_mask", 8'(bus.split_mask), 8'(e.msk));
    chk("err_pulse", 8'(bus.err_pulse), 8'(e.err));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_g1"},  8'(bus.grant_1), 8'd0);
    chk({tag, "_g2"},  8'(bus.grant_2), 8'd0);
    chk({tag, "_mid"}, 8'(bus.master_id), 8'd0);
    chk({tag, "_msk"}, 8'(bus.split_mask), 8'd0);
    chk({tag, "_err"}, 8'(bus.err_pulse), 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.busreq_1 = 0; bus.busreq_2 = 0; bus.ready = 0;
    bus.response = 2'b00; bus.split_clr_1 = 0; bus.split_clr_2 = 0;
    model_reset();
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single request: grant after one edge, master_id one ready edge later.
    cyc(1, 0, 1, 2'b00);
    chk("single_grant1", 8'(bus.grant_1), 8'd1);
    chk("single_mid_idle", 8'(bus.master_id), 8'd0);
    cyc(1, 0, 1, 2'b00);
    chk("single_mid1", 8'(bus.master_id), 8'd1);

    // ERROR: one-cycle pulse, grant untouched.
    cyc(1, 0, 1, 2'b01);
    chk("err_high", 8'(bus.err_pulse), 8'd1);
    chk("err_grant", 8'(bus.grant_1), 8'd1);
    cyc(1, 0, 1, 2'b00);
    chk("err_low", 8'(bus.err_pulse), 8'd0);

    // Stall with competitor: beat_cnt is saturated at 3, handoff on first ready.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 2'b11);
      chk("stall_hold", 8'(bus.grant_1), 8'd1);
    end
    cyc(1, 1, 1, 2'b00);
    chk("stall_handoff", 8'(bus.grant_2), 8'd1);

    // RETRY moves the grant to the requesting other master.
    cyc(1, 1, 1, 2'b10);
    chk("retry_moves", 8'(bus.grant_1), 8'd1);

    // SPLIT parks master 1; master 2 takes over until the clear.
    cyc(1, 1, 1, 2'b11);
    chk("split_mask", 8'(bus.split_mask), 8'd1);
    chk("split_grant2", 8'(bus.grant_2), 8'd1);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 2'b00);
    chk("split_hold2", 8'(bus.grant_2), 8'd1);
    cyc(1, 1, 1, 2'b00, 1'b1, 1'b0);
    chk("split_cleared", 8'(bus.split_mask), 8'd0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 2'b00);

    // Alternation under continuous contention.
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, 2'b00);

    // Reach OWN2 with master 1 parked, then reset between edges.
    while (m_st != 1) cyc(1, 1, 1, 2'b00);
    cyc(1, 1, 1, 2'b11);
    chk("pre_reset_own2", 8'(bus.grant_2), 8'd1);
    #1 rst = 1'b1;
    #1 chk_reset_vals("async_reset");
    #1 rst = 1'b0;
    model_reset();

    // Tie from IDLE right after reset: master 1 wins in both modes.
    cyc(1, 1, 1, 2'b00);
    chk("tie_first", 8'(bus.grant_1), 8'd1);

    // Randomised traffic checked against the reference model.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 7);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) != 0, (r < 4) ? 2'b00 : 2'(r - 4),
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
